// File: rtl/spectral_bin_proc.sv
// Per-bin complex gain between the streaming fft and ifft: 3-stage pipeline with bypass/gain/mute/conjugate-gain modes.
// Define SPECTRAL_BIN_PROC_SAT_EN to saturate results; otherwise they wrap to WIDTH bits.
`timescale 1ns/1ps
module spectral_bin_proc #(
  parameter int WIDTH     = 32,
  parameter int N         = 64,
  parameter int COEF_W    = 16,
  parameter int COEF_FRAC = 14,
  localparam int AW       = $clog2(N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_in_en,
  input  logic [WIDTH-1:0]  data_in_re,
  input  logic [WIDTH-1:0]  data_in_im,
  input  logic              sync_in,
  input  logic [1:0]        mode,
  input  logic              coef_we,
  input  logic [AW-1:0]     coef_addr,
  input  logic [COEF_W-1:0] coef_re,
  input  logic [COEF_W-1:0] coef_im,
  output logic              data_out_en,
  output logic [WIDTH-1:0]  data_out_re,
  output logic [WIDTH-1:0]  data_out_im,
  output logic [AW-1:0]     bin_idx_out,
  output logic              frame_done,
  output logic              sync_err
);
  localparam int STAGES = 3;
  localparam int PW     = WIDTH + COEF_W;
  localparam int SW     = PW + 1;
  localparam logic signed [SW-1:0] RND = SW'(1) << (COEF_FRAC - 1);
`ifdef SPECTRAL_BIN_PROC_SAT_EN
  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;
`endif

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;
  state_t r_state, w_state_nxt;

  logic [AW-1:0]     r_bin, w_idx;
  logic              w_first, w_last;
  logic [1:0]        r_mode, w_mode;
  logic              r_sync_pend, r_sync_err;
  logic [STAGES-1:0] r_vld_pipe;

  logic [COEF_W-1:0] r_coef_re [N];
  logic [COEF_W-1:0] r_coef_im [N];

  logic [WIDTH-1:0]  r1_a, r1_b;
  logic [COEF_W-1:0] r1_c, r1_d;
  logic [AW-1:0]     r1_idx;
  logic              r1_last;
  logic [1:0]        r1_mode;
  logic signed [PW-1:0] w1_a, w1_b, w1_c, w1_d;

  logic signed [PW-1:0] r2_ac, r2_bd, r2_ad, r2_bc;
  logic [WIDTH-1:0]  r2_a, r2_b;
  logic [AW-1:0]     r2_idx;
  logic              r2_last;
  logic [1:0]        r2_mode;

  logic signed [SW-1:0] w3_ac, w3_bd, w3_ad, w3_bc, w3_re_sum, w3_im_sum;
  logic [WIDTH-1:0]  w3_re, w3_im;

  logic [WIDTH-1:0]  r_out_re, r_out_im;
  logic [AW-1:0]     r_out_idx;
  logic              r_frame_done;

  function automatic logic [WIDTH-1:0] f_scale(input logic signed [SW-1:0] v);
    logic signed [SW-1:0] sh;
    sh = (v + RND) >>> COEF_FRAC;
`ifdef SPECTRAL_BIN_PROC_SAT_EN
    if (sh > SAT_MAX) return SAT_MAX[WIDTH-1:0];
    if (sh < SAT_MIN) return SAT_MIN[WIDTH-1:0];
`endif
    return sh[WIDTH-1:0];
  endfunction

  // A pending or concurrent sync forces this sample to bin 0; mode latches on bin 0.
  always_comb begin
    w_idx       = (sync_in || r_sync_pend) ? '0 : r_bin;
    w_first     = (w_idx == '0);
    w_last      = (w_idx == AW'(N - 1));
    w_mode      = w_first ? mode : r_mode;
    w_state_nxt = r_state;
    if (data_in_en) begin
      if (w_first)     w_state_nxt = S_ACTIVE;
      else if (w_last) w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bin       <= '0;
      r_mode      <= '0;
      r_sync_pend <= 1'b0;
      r_sync_err  <= 1'b0;
    end else begin
      if (data_in_en) begin
        r_bin       <= w_last ? '0 : w_idx + AW'(1);
        r_mode      <= w_mode;
        r_sync_pend <= 1'b0;
      end else if (sync_in) begin
        r_sync_pend <= 1'b1;
      end
      if (sync_in && r_state == S_ACTIVE) r_sync_err <= 1'b1;
    end
  end

  // Coefficient RAM is not reset; the S1 read sees the pre-write value on a same-address write.
  always_ff @(posedge clk) begin
    if (coef_we) begin
      r_coef_re[coef_addr] <= coef_re;
      r_coef_im[coef_addr] <= coef_im;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_vld_pipe <= '0;
    else       r_vld_pipe <= {r_vld_pipe[STAGES-2:0], data_in_en};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r1_a <= '0; r1_b <= '0; r1_c <= '0; r1_d <= '0;
      r1_idx <= '0; r1_last <= 1'b0; r1_mode <= '0;
    end else if (data_in_en) begin
      r1_a    <= data_in_re;
      r1_b    <= data_in_im;
      r1_c    <= r_coef_re[w_idx];
      r1_d    <= r_coef_im[w_idx];
      r1_idx  <= w_idx;
      r1_last <= w_last;
      r1_mode <= w_mode;
    end
  end

  always_comb begin
    w1_a = {{COEF_W{r1_a[WIDTH-1]}}, r1_a};
    w1_b = {{COEF_W{r1_b[WIDTH-1]}}, r1_b};
    w1_c = {{WIDTH{r1_c[COEF_W-1]}}, r1_c};
    w1_d = {{WIDTH{r1_d[COEF_W-1]}}, r1_d};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r2_ac <= '0; r2_bd <= '0; r2_ad <= '0; r2_bc <= '0;
      r2_a <= '0; r2_b <= '0; r2_idx <= '0; r2_last <= 1'b0; r2_mode <= '0;
    end else if (r_vld_pipe[0]) begin
      r2_ac   <= w1_a * w1_c;
      r2_bd   <= w1_b * w1_d;
      r2_ad   <= w1_a * w1_d;
      r2_bc   <= w1_b * w1_c;
      r2_a    <= r1_a;
      r2_b    <= r1_b;
      r2_idx  <= r1_idx;
      r2_last <= r1_last;
      r2_mode <= r1_mode;
    end
  end

  // Conjugate gain flips the sign of d through the products, avoiding -d overflow on the coef.
  always_comb begin
    w3_ac = {r2_ac[PW-1], r2_ac};
    w3_bd = {r2_bd[PW-1], r2_bd};
    w3_ad = {r2_ad[PW-1], r2_ad};
    w3_bc = {r2_bc[PW-1], r2_bc};
    if (r2_mode == 2'd3) begin
      w3_re_sum = w3_ac + w3_bd;
      w3_im_sum = w3_bc - w3_ad;
    end else begin
      w3_re_sum = w3_ac - w3_bd;
      w3_im_sum = w3_ad + w3_bc;
    end
    w3_re = f_scale(w3_re_sum);
    w3_im = f_scale(w3_im_sum);
    case (r2_mode)
      2'd0: begin w3_re = r2_a; w3_im = r2_b; end
      2'd2: begin w3_re = '0;   w3_im = '0;   end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_re     <= '0;
      r_out_im     <= '0;
      r_out_idx    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= r_vld_pipe[1] & r2_last;
      if (r_vld_pipe[1]) begin
        r_out_re  <= w3_re;
        r_out_im  <= w3_im;
        r_out_idx <= r2_idx;
      end
    end
  end

  assign data_out_en = r_vld_pipe[STAGES-1];
  assign data_out_re = r_out_re;
  assign data_out_im = r_out_im;
  assign bin_idx_out = r_out_idx;
  assign frame_done  = r_frame_done;
  assign sync_err    = r_sync_err;
endmodule
